cnt_seq_ctrl: RTL and testbench

//  Sequencing controller for the board counter datapath (mod 8/10/16, up/down, load).

---
 rtl/cnt_seq_pkg.sv | 37 +++
 rtl/btn_debounce.sv | 46 ++++
 rtl/cnt_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_cnt_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: shared types and helpers for the counter sequencing controller.
package cnt_seq_pkg;

    localparam int MOD_W = 5;

    typedef enum logic [1:0] {
        MOD_SEL_8      = 2'b00,
        MOD_SEL_10     = 2'b01,
        MOD_SEL_16     = 2'b10,
        MOD_SEL_16_ALT = 2'b11
    } mod_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_e;

    function automatic logic [MOD_W-1:0] mod_value(input mod_sel_e sel);
        case (sel)
            MOD_SEL_8:  return MOD_W'(8);
            MOD_SEL_10: return MOD_W'(10);
            default:    return MOD_W'(16);
        endcase
    endfunction

    // Keep a loaded value inside the range the counter can actually hold.
    function automatic logic [3:0] clamp_load(input logic [3:0] data, input logic [MOD_W-1:0] modv);
        if (modv == MOD_W'(8))
            return data & 4'd7;
        else if (modv == MOD_W'(10))
            return (data > 4'd9) ? 4'd9 : data;
        else
            return data;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: accepts a new level only after it has been stable for DB_CYCLES
// synced cycles; press pulses for one cycle when the debounced level rises.
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // The counter only runs while the input disagrees with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (din != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1))
                level_d = din;
            else
                cnt_d = cnt_q + CW'(1);
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: board-side sequencing controller for the mod 8/10/16 counter.
// Define CNT_SEQ_CTRL_STEP_EN to enable the single-step button (btn_pin[1]) while idle.
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int TICK_DIV  = 100,
    parameter int DB_CYCLES = 16,
    parameter int DW        = 4
) (
    input  logic             sys_clk_in,
    input  logic             sys_rst,
    input  logic [7:0]       sw_pin,
    input  logic [4:0]       btn_pin,
    output logic             cnt_tick,
    output logic             cnt_dir,
    output logic [MOD_W-1:0] cnt_mod,
    output logic             cnt_load,
    output logic [DW-1:0]    cnt_load_data,
    output logic             cnt_clr,
    output logic             cfg_busy
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [7:0]       sw_meta_q, sw_sync_q;
    logic [4:0]       btn_meta_q, btn_sync_q;
    logic [PW-1:0]    presc_q, presc_d;
    state_e           state_q, state_d;
    logic [MOD_W-1:0] mod_q, mod_d, shadow_mod_q, shadow_mod_d, sw_mod;
    logic             dir_q, dir_d, shadow_dir_q, shadow_dir_d;
    logic             tick_q, tick_d, load_q, load_d, clr_q, clr_d;
    logic [DW-1:0]    load_data_q, load_data_d;
    logic             en, wrap, run_tick, step_tick;
    logic             clr_press, load_press, step_press;
    logic             clr_level_unused, load_level_unused, unused_btn;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clock(sys_clk_in), .reset(sys_rst), .din(btn_sync_q[0]),
        .level(clr_level_unused), .press(clr_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
        .clock(sys_clk_in), .reset(sys_rst), .din(btn_sync_q[3]),
        .level(load_level_unused), .press(load_press)
    );

`ifdef CNT_SEQ_CTRL_STEP_EN
    logic step_level_unused;
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clock(sys_clk_in), .reset(sys_rst), .din(btn_sync_q[1]),
        .level(step_level_unused), .press(step_press)
    );
    assign unused_btn = ^{btn_sync_q[4], btn_sync_q[2]};
`else
    assign step_press = 1'b0;
    assign unused_btn = ^{btn_sync_q[4], btn_sync_q[2], btn_sync_q[1]};
`endif

    // Config is only ever adopted in IDLE or at a step boundary, so the counter never
    // sees a modulus change in the middle of a count period.
    always_comb begin
        en           = sw_sync_q[7];
        sw_mod       = mod_value(mod_sel_e'(sw_sync_q[5:4]));
        wrap         = (presc_q == PW'(TICK_DIV - 1));
        presc_d      = (en && !wrap) ? presc_q + PW'(1) : '0;
        state_d      = state_q;
        mod_d        = mod_q;
        dir_d        = dir_q;
        shadow_mod_d = shadow_mod_q;
        shadow_dir_d = shadow_dir_q;
        run_tick     = 1'b0;
        case (state_q)
            S_IDLE: begin
                mod_d = sw_mod;
                dir_d = sw_sync_q[6];
                if (en) state_d = S_RUN;
            end
            S_RUN: begin
                shadow_mod_d = sw_mod;
                shadow_dir_d = sw_sync_q[6];
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    run_tick = wrap;
                    if (sw_mod != mod_q || sw_sync_q[6] != dir_q) state_d = S_PEND;
                end
            end
            S_PEND: begin
                shadow_mod_d = sw_mod;
                shadow_dir_d = sw_sync_q[6];
                if (!en) begin
                    state_d = S_IDLE;
                end else if (wrap) begin
                    mod_d   = shadow_mod_q;
                    dir_d   = shadow_dir_q;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shrinking the modulus could strand the count out of range, so clear it.
        step_tick   = step_press && (state_q == S_IDLE);
        clr_d       = clr_press | (mod_d < mod_q);
        load_d      = load_press & ~clr_d;
        tick_d      = (run_tick | step_tick) & ~clr_d & ~load_d;
        load_data_d = load_d ? DW'(clamp_load(sw_sync_q[3:0], mod_q)) : load_data_q;
    end

    always_ff @(posedge sys_clk_in) begin
        if (sys_rst) begin
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            btn_meta_q   <= '0;
            btn_sync_q   <= '0;
            presc_q      <= '0;
            state_q      <= S_IDLE;
            mod_q        <= MOD_W'(8);
            dir_q        <= 1'b1;
            shadow_mod_q <= MOD_W'(8);
            shadow_dir_q <= 1'b1;
            tick_q       <= 1'b0;
            load_q       <= 1'b0;
            clr_q        <= 1'b0;
            load_data_q  <= '0;
        end else begin
            sw_meta_q    <= sw_pin;
            sw_sync_q    <= sw_meta_q;
            btn_meta_q   <= btn_pin;
            btn_sync_q   <= btn_meta_q;
            presc_q      <= presc_d;
            state_q      <= state_d;
            mod_q        <= mod_d;
            dir_q        <= dir_d;
            shadow_mod_q <= shadow_mod_d;
            shadow_dir_q <= shadow_dir_d;
            tick_q       <= tick_d;
            load_q       <= load_d;
            clr_q        <= clr_d;
            load_data_q  <= load_data_d;
        end
    end

    assign cnt_tick      = tick_q;
    assign cnt_dir       = dir_q;
    assign cnt_mod       = mod_q;
    assign cnt_load      = load_q;
    assign cnt_load_data = load_data_q;
    assign cnt_clr       = clr_q;
    assign cfg_busy      = (state_q == S_PEND);

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: scoreboard bench for cnt_seq_ctrl with TICK_DIV=4, DB_CYCLES=4.
// Expected strobe events (kind, cycle, data) are queued with the stimulus and matched against a monitor.
module tb_cnt_seq_ctrl;

    localparam int EV_TICK = 0;
    localparam int EV_LOAD = 1;
    localparam int EV_CLR  = 2;

    typedef struct {
        int         kind;
        int         at;
        logic [3:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic [7:0] sw_pin;
    logic [4:0] btn_pin;
    logic       cnt_tick, cnt_dir, cnt_load, cnt_clr, cfg_busy;
    logic [4:0] cnt_mod;
    logic [3:0] cnt_load_data;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    cnt_seq_ctrl #(.TICK_DIV(4), .DB_CYCLES(4), .DW(4)) dut (
        .sys_clk_in(clk), .sys_rst(sys_rst), .sw_pin(sw_pin), .btn_pin(btn_pin),
        .cnt_tick(cnt_tick), .cnt_dir(cnt_dir), .cnt_mod(cnt_mod), .cnt_load(cnt_load),
        .cnt_load_data(cnt_load_data), .cnt_clr(cnt_clr), .cfg_busy(cfg_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with the number of rising edges seen so far.
    always @(negedge clk) begin
        if (!sys_rst) begin
            if (cnt_tick) obs_q.push_back('{EV_TICK, cyc, 4'd0});
            if (cnt_load) obs_q.push_back('{EV_LOAD, cyc, cnt_load_data});
            if (cnt_clr)  obs_q.push_back('{EV_CLR, cyc, 4'd0});
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sys_rst = 1'b1;
        sw_pin  = 8'h00;
        btn_pin = 5'b0;
        repeat (5) @(negedge clk);
        sys_rst = 1'b0;
        repeat (12) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        sys_rst = 1'b1;
        sw_pin  = 8'h00;
        btn_pin = 5'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (cnt_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tick: got %b want 0", cnt_tick); end
        n_checks++; if (cnt_load !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_load: got %b want 0", cnt_load); end
        n_checks++; if (cnt_clr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_clr: got %b want 0", cnt_clr); end
        n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", cfg_busy); end
        n_checks++; if (cnt_mod !== 5'd8) begin n_fail++; $display("[TB] FAIL reset_mod: got %0d want 8", cnt_mod); end
        n_checks++; if (cnt_dir !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_dir: got %b want 1", cnt_dir); end
        n_checks++; if (cnt_load_data !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_data: got %0d want 0", cnt_load_data); end
        sys_rst = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL idle_quiet: got %0d events want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_run();
        int  t0;
        ev_t o, e;
        do_reset();
        t0 = cyc;
        sw_pin = 8'hC3;
        for (int k = 0; k < 4; k++) exp_q.push_back('{EV_TICK, t0 + 6 + 4 * k, 4'd0});
        wait_until(t0 + 8);
        n_checks++; if (cnt_mod !== 5'd8) begin n_fail++; $display("[TB] FAIL run_mod: got %0d want 8", cnt_mod); end
        n_checks++; if (cnt_dir !== 1'b1) begin n_fail++; $display("[TB] FAIL run_dir: got %b want 1", cnt_dir); end
        n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL run_busy: got %b want 0", cfg_busy); end
        wait_until(t0 + 19);
        sw_pin = 8'h43;
        wait_until(t0 + 40);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("[TB] FAIL run_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o.kind !== e.kind || o.at !== e.at || o.data !== e.data) begin
                n_fail++; $display("[TB] FAIL run_event: got kind=%0d at=%0d data=%0d want kind=%0d at=%0d data=%0d", o.kind, o.at, o.data, e.kind, e.at, e.data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_cfg_change();
        int  t0;
        ev_t o, e;
        do_reset();
        t0 = cyc;
        sw_pin = 8'hC3;
        exp_q.push_back('{EV_TICK, t0 + 6, 4'd0});
        exp_q.push_back('{EV_TICK, t0 + 10, 4'd0});
        exp_q.push_back('{EV_TICK, t0 + 14, 4'd0});
        exp_q.push_back('{EV_TICK, t0 + 22, 4'd0});
        exp_q.push_back('{EV_TICK, t0 + 26, 4'd0});
        exp_q.push_back('{EV_CLR, t0 + 30, 4'd0});
        exp_q.push_back('{EV_TICK, t0 + 34, 4'd0});
        wait_until(t0 + 12);
        sw_pin = 8'hE3;
        wait_until(t0 + 16);
        n_checks++; if (cfg_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL up_busy: got %b want 1", cfg_busy); end
        n_checks++; if (cnt_mod !== 5'd8) begin n_fail++; $display("[TB] FAIL up_mod_hold: got %0d want 8", cnt_mod); end
        wait_until(t0 + 18);
        n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL up_busy_done: got %b want 0", cfg_busy); end
        n_checks++; if (cnt_mod !== 5'd16) begin n_fail++; $display("[TB] FAIL up_mod_apply: got %0d want 16", cnt_mod); end
        wait_until(t0 + 24);
        sw_pin = 8'hC3;
        wait_until(t0 + 28);
        n_checks++; if (cfg_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL down_busy: got %b want 1", cfg_busy); end
        n_checks++; if (cnt_mod !== 5'd16) begin n_fail++; $display("[TB] FAIL down_mod_hold: got %0d want 16", cnt_mod); end
        wait_until(t0 + 30);
        n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL down_busy_done: got %b want 0", cfg_busy); end
        n_checks++; if (cnt_mod !== 5'd8) begin n_fail++; $display("[TB] FAIL down_mod_apply: got %0d want 8", cnt_mod); end
        wait_until(t0 + 35);
        sw_pin = 8'h43;
        wait_until(t0 + 50);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("[TB] FAIL cfg_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o.kind !== e.kind || o.at !== e.at || o.data !== e.data) begin
                n_fail++; $display("[TB] FAIL cfg_event: got kind=%0d at=%0d data=%0d want kind=%0d at=%0d data=%0d", o.kind, o.at, o.data, e.kind, e.at, e.data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_load_clamp();
        int  t0, t1, t2;
        ev_t o, e;
        do_reset();
        t0 = cyc;
        sw_pin = 8'h5C;
        t1 = t0 + 5;
        wait_until(t1);
        n_checks++; if (cnt_mod !== 5'd10) begin n_fail++; $display("[TB] FAIL load_mod: got %0d want 10", cnt_mod); end
        btn_pin = 5'b01000;
        exp_q.push_back('{EV_LOAD, t1 + 7, 4'd9});
        wait_until(t1 + 6);
        btn_pin = 5'b00000;
        t2 = t1 + 16;
        wait_until(t2);
        btn_pin = 5'b01000;
        wait_until(t2 + 2);
        btn_pin = 5'b00000;
        wait_until(t2 + 15);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("[TB] FAIL load_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o.kind !== e.kind || o.at !== e.at || o.data !== e.data) begin
                n_fail++; $display("[TB] FAIL load_event: got kind=%0d at=%0d data=%0d want kind=%0d at=%0d data=%0d", o.kind, o.at, o.data, e.kind, e.at, e.data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_priority();
        int  t0;
        ev_t o, e;
        do_reset();
        t0 = cyc;
        btn_pin = 5'b01001;
        exp_q.push_back('{EV_CLR, t0 + 7, 4'd0});
        wait_until(t0 + 6);
        btn_pin = 5'b00000;
        t0 = t0 + 20;
        wait_until(t0);
        sw_pin = 8'hC3;
        exp_q.push_back('{EV_TICK, t0 + 6, 4'd0});
        exp_q.push_back('{EV_TICK, t0 + 10, 4'd0});
        exp_q.push_back('{EV_TICK, t0 + 14, 4'd0});
        exp_q.push_back('{EV_LOAD, t0 + 18, 4'd3});
        exp_q.push_back('{EV_TICK, t0 + 22, 4'd0});
        exp_q.push_back('{EV_TICK, t0 + 26, 4'd0});
        wait_until(t0 + 11);
        btn_pin = 5'b01000;
        wait_until(t0 + 17);
        btn_pin = 5'b00000;
        wait_until(t0 + 27);
        sw_pin = 8'h43;
        wait_until(t0 + 40);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("[TB] FAIL prio_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o.kind !== e.kind || o.at !== e.at || o.data !== e.data) begin
                n_fail++; $display("[TB] FAIL prio_event: got kind=%0d at=%0d data=%0d want kind=%0d at=%0d data=%0d", o.kind, o.at, o.data, e.kind, e.at, e.data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_step();
        int  t0;
        ev_t o, e;
        do_reset();
        t0 = cyc;
        btn_pin = 5'b00010;
`ifdef CNT_SEQ_CTRL_STEP_EN
        exp_q.push_back('{EV_TICK, t0 + 7, 4'd0});
`endif
        wait_until(t0 + 6);
        btn_pin = 5'b00000;
        wait_until(t0 + 20);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("[TB] FAIL step_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o.kind !== e.kind || o.at !== e.at || o.data !== e.data) begin
                n_fail++; $display("[TB] FAIL step_event: got kind=%0d at=%0d data=%0d want kind=%0d at=%0d data=%0d", o.kind, o.at, o.data, e.kind, e.at, e.data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        sys_rst = 1'b1;
        sw_pin  = 8'h00;
        btn_pin = 5'b0;
        @(negedge clk);
        test_reset();
        test_run();
        test_cfg_change();
        test_load_clamp();
        test_priority();
        test_step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
